wb_grf: RTL

- Writeback stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs: selects the writeback source, applies load byte/half extraction and extension, and commits the result to a 32x32 register file.
- Provides two combinational read ports to the decode stage, with internal write-to-read bypass.

---
 rtl/wb_grf.sv | 101 ++++++++++
 1 files changed

// File: rtl/wb_grf.sv
// wb_grf: MIPS writeback stage. Selects the writeback source, extracts and extends
// load data, and commits to a 32x32 register file with two bypassed read ports.
module wb_grf #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    MemtoReg_in,
    input  logic          RegWrite_in,
    input  logic [DW-1:0] dmOut_in,
    input  logic [DW-1:0] ALUS_in,
    input  logic [4:0]    WReg_in,
    input  logic [DW-1:0] pc8_in,
    input  logic [2:0]    load_ext_op_in,
    input  logic [DW-1:0] HILO_in,
    input  logic [4:0]    RA1,
    input  logic [4:0]    RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic [DW-1:0] WD_out,
    output logic [31:0]   wb_cnt
);

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_data;
    logic [DW-1:0] wd_sel;
    logic          commit;

    logic [DW-1:0] regs_reg [NREG];
    logic [31:0]   wb_cnt_reg;

    always_comb begin
        byte_sel  = dmOut_in[7:0];
        half_sel  = ALUS_in[1] ? dmOut_in[31:16] : dmOut_in[15:0];
        load_data = dmOut_in;
        wd_sel    = ALUS_in;

        case (ALUS_in[1:0])
            2'd0:    byte_sel = dmOut_in[7:0];
            2'd1:    byte_sel = dmOut_in[15:8];
            2'd2:    byte_sel = dmOut_in[23:16];
            default: byte_sel = dmOut_in[31:24];
        endcase

        // Codes 5..7 are unassigned and fall back to a plain word load.
        case (load_ext_op_in)
            3'd1:    load_data = {{(DW-8){1'b0}}, byte_sel};
            3'd2:    load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
            3'd3:    load_data = {{(DW-16){1'b0}}, half_sel};
            3'd4:    load_data = {{(DW-16){half_sel[15]}}, half_sel};
            default: load_data = dmOut_in;
        endcase

        case (MemtoReg_in)
            2'd0:    wd_sel = ALUS_in;
            2'd1:    wd_sel = load_data;
            2'd2:    wd_sel = pc8_in;
            default: wd_sel = HILO_in;
        endcase
    end

    assign WD_out = rst ? wd_sel : '0;
    assign commit = RegWrite_in && (WReg_in != 5'd0);

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            wb_cnt_reg <= '0;
        end else if (commit) begin
            for (int i = 1; i < NREG; i++) begin
                if (WReg_in == i[4:0]) begin
                    regs_reg[i] <= wd_sel;
                end
            end
            wb_cnt_reg <= wb_cnt_reg + 32'd1;
        end
    end

    assign wb_cnt = wb_cnt_reg;

    // Each read port bypasses the in-flight write independently.
    logic [1:0][4:0]    ra;
    logic [1:0][DW-1:0] rd;

    assign ra = {RA2, RA1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rd[gi] = (!rst || ra[gi] == 5'd0)                ? '0 :
                        (RegWrite_in && WReg_in == ra[gi])      ? wd_sel :
                                                                  regs_reg[ra[gi]];
    end

    assign RD1 = rd[0];
    assign RD2 = rd[1];

endmodule
